// File: rtl/mii_tx_pkg.sv
// mii_tx_pkg: shared definitions for the MII transmit framer.
// Holds the framer state encoding, the preamble/SFD nibbles, the CRC-32
// constants and a nibble-serial CRC-32 helper that the receive checker
// uses as well.
package mii_tx_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

  // Reflected CRC-32, four data bits per call, LSB of the nibble first
  // (matching the order the bits leave on the wire).
  function automatic logic [31:0] crc32_nib(input logic [31:0] crc,
                                            input logic [3:0]  nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC_POLY;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_nib_update.sv
// crc32_nib_update: combinational one-nibble step of the reflected CRC-32.
// Ports:
//   crc      in  32  current CRC register
//   nib      in  4   nibble to absorb (bit 0 first)
//   crc_next out 32  CRC register after absorbing nib
module crc32_nib_update
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  assign crc_next = crc32_nib(crc, nib);

endmodule

// File: rtl/mii_tx_frame.sv
// mii_tx_frame: MII (100Base) transmit framer.
// Takes 64-bit payload words and drives the PHY nibble bus with
// preamble/SFD, payload (low nibble of each byte first), zero pad up to
// MIN_PAYLOAD_BYTES, the CRC-32 FCS, then holds the line idle for the
// inter-frame gap.
// Ports:
//   clk_25Mz  in      MII transmit clock (rising edge)
//   RESET_N   in      synchronous active-low reset
//   s_data    in  64  payload word, byte 0 in [7:0]
//   s_valid   in      s_data valid
//   s_last    in      last word of the frame
//   s_bytes   in  4   valid bytes in the last word (1..8)
//   s_ready   out     word accepted when s_valid && s_ready
//   COL       in      PHY collision indication
//   TX_EN     out     transmit enable (registered)
//   TRAN_DATA out 4   transmit nibble (registered)
//   busy      out     not idle
//   done      out     pulse on the last FCS nibble
//   underrun  out     pulse when a frame is aborted for lack of data
//   col_seen  out     sticky collision flag, cleared on next frame accept
module mii_tx_frame
  import mii_tx_pkg::*;
#(
  parameter int MIN_PAYLOAD_BYTES = 60,
  parameter int IFG_NIBBLES       = 24
) (
  input  logic              clk_25Mz,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  input  logic [3:0]        s_bytes,
  output logic              s_ready,
  input  logic              COL,
  output logic              TX_EN,
  output logic [3:0]        TRAN_DATA,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              col_seen
);

  localparam logic [11:0] MIN_B = 12'(MIN_PAYLOAD_BYTES);
  // The IDLE cycle that accepts the next frame is itself an idle nibble on
  // the wire, so the IFG state lasts one cycle less than the gap.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 2);

  state_t              state, state_d;
  logic [7:0]          cnt, cnt_d;
  logic [10:0]         byte_cnt, byte_cnt_d, byte_inc;
  logic [DATA_W-1:0]   sr, sr_d;
  logic                last, last_d;
  logic [3:0]          nbytes, nbytes_d, nbytes_eff;
  logic [31:0]         crc, crc_d, crc_upd;
  logic                crc_we, crc_init;
  logic                tx_en_d;
  logic [3:0]          txd_d;
  logic [4:0]          word_nibs;
  logic                word_end;
  logic                pad_needed;
  logic                accept;

  // Out-of-range byte counts are treated as a full word.
  assign nbytes_eff = (nbytes == 4'd0 || nbytes > 4'd8) ? 4'd8 : nbytes;
  assign word_nibs  = last ? {nbytes_eff, 1'b0} : 5'd16;
  assign word_end   = (cnt == {3'b000, word_nibs - 5'd1});

  // Bytes completed once the nibble now on the pins is counted, if it is
  // the high nibble of its byte.
  assign byte_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign pad_needed = (MIN_B != 12'd0) && ({1'b0, byte_inc} < MIN_B);

  assign s_ready  = RESET_N &&
                    ((state == ST_IDLE) ||
                     (state == ST_DATA && word_end && !last));
  assign accept   = s_valid && s_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FCS) && (cnt == 8'd7);
  assign underrun = (state == ST_DATA) && word_end && !last && !s_valid;

  // The CRC absorbs exactly the payload/pad nibble being loaded onto the pins.
  crc32_nib_update u_crc (
    .crc      (crc),
    .nib      (txd_d),
    .crc_next (crc_upd)
  );

  assign crc_d = crc_init ? CRC_INIT : (crc_we ? crc_upd : crc);

  // State names the nibble currently on the pins; this block chooses the
  // next nibble so the pin register never lags the sequencing.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    byte_cnt_d = byte_cnt;
    sr_d       = sr;
    last_d     = last;
    nbytes_d   = nbytes;
    tx_en_d    = 1'b0;
    txd_d      = 4'h0;
    crc_we     = 1'b0;
    crc_init   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) begin
          sr_d       = s_data;
          last_d     = s_last;
          nbytes_d   = s_bytes;
          cnt_d      = 8'd0;
          byte_cnt_d = 11'd0;
          crc_init   = 1'b1;
          state_d    = ST_PRE;
          tx_en_d    = 1'b1;
          txd_d      = PREAMBLE_NIBBLE;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        cnt_d   = cnt + 8'd1;
        if (cnt == 8'd14) begin
          txd_d = SFD_NIBBLE;
        end else if (cnt == 8'd15) begin
          state_d = ST_DATA;
          cnt_d   = 8'd0;
          txd_d   = sr[3:0];
          sr_d    = sr >> 4;
          crc_we  = 1'b1;
        end else begin
          txd_d = PREAMBLE_NIBBLE;
        end
      end
      ST_DATA: begin
        if (cnt[0]) byte_cnt_d = byte_inc;
        if (!word_end) begin
          tx_en_d = 1'b1;
          txd_d   = sr[3:0];
          sr_d    = sr >> 4;
          cnt_d   = cnt + 8'd1;
          crc_we  = 1'b1;
        end else if (!last) begin
          if (s_valid) begin
            last_d   = s_last;
            nbytes_d = s_bytes;
            tx_en_d  = 1'b1;
            txd_d    = s_data[3:0];
            sr_d     = s_data >> 4;
            cnt_d    = 8'd0;
            crc_we   = 1'b1;
          end else begin
            state_d = ST_IFG;
            cnt_d   = 8'd0;
          end
        end else if (pad_needed) begin
          state_d = ST_PAD;
          cnt_d   = 8'd0;
          tx_en_d = 1'b1;
          crc_we  = 1'b1;
        end else begin
          state_d = ST_FCS;
          cnt_d   = 8'd0;
          tx_en_d = 1'b1;
          txd_d   = ~crc[3:0];
          sr_d    = {32'h0, ~crc} >> 4;
        end
      end
      ST_PAD: begin
        // Pad starts on a byte boundary, so cnt[0] marks the high nibble.
        if (cnt[0]) byte_cnt_d = byte_inc;
        if (cnt[0] && !pad_needed) begin
          state_d = ST_FCS;
          cnt_d   = 8'd0;
          tx_en_d = 1'b1;
          txd_d   = ~crc[3:0];
          sr_d    = {32'h0, ~crc} >> 4;
        end else begin
          tx_en_d = 1'b1;
          cnt_d   = cnt + 8'd1;
          crc_we  = 1'b1;
        end
      end
      ST_FCS: begin
        cnt_d = cnt + 8'd1;
        if (cnt == 8'd7) begin
          state_d = ST_IFG;
          cnt_d   = 8'd0;
        end else begin
          tx_en_d = 1'b1;
          txd_d   = sr[3:0];
          sr_d    = sr >> 4;
        end
      end
      ST_IFG: begin
        cnt_d = cnt + 8'd1;
        if (cnt == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_25Mz) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      byte_cnt  <= 11'd0;
      TX_EN     <= 1'b0;
      TRAN_DATA <= 4'h0;
      col_seen  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      byte_cnt  <= byte_cnt_d;
      TX_EN     <= tx_en_d;
      TRAN_DATA <= txd_d;
      if (accept && state == ST_IDLE) col_seen <= 1'b0;
      else if (COL && TX_EN)          col_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_25Mz) begin
    sr     <= sr_d;
    last   <= last_d;
    nbytes <= nbytes_d;
    crc    <= crc_d;
  end

endmodule

// File: tb/tb_mii_tx_frame.sv
// tb_mii_tx_frame: randomized self-checking bench for mii_tx_frame.
// Two instances: u_pad (default parameters) and u_nopad (no padding).
// Expected wire streams come from a byte-level framing model with a
// bitwise CRC-32.
module tb_mii_tx_frame;

  localparam logic [31:0] POLY  = 32'hEDB88320;
  localparam int          LIMIT = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_data  [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic [3:0]  s_bytes [2];
  logic        s_ready [2];
  logic        col     [2];
  logic        tx_en   [2];
  logic [3:0]  txd     [2];
  logic        busy    [2];
  logic        done    [2];
  logic        underrun[2];
  logic        col_seen[2];

  always #20 clk = ~clk;

  mii_tx_frame u_pad (
    .clk_25Mz(clk), .RESET_N(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .s_bytes(s_bytes[0]), .s_ready(s_ready[0]), .COL(col[0]),
    .TX_EN(tx_en[0]), .TRAN_DATA(txd[0]), .busy(busy[0]), .done(done[0]),
    .underrun(underrun[0]), .col_seen(col_seen[0])
  );

  mii_tx_frame #(.MIN_PAYLOAD_BYTES(0), .IFG_NIBBLES(24)) u_nopad (
    .clk_25Mz(clk), .RESET_N(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .s_bytes(s_bytes[1]), .s_ready(s_ready[1]), .COL(col[1]),
    .TX_EN(tx_en[1]), .TRAN_DATA(txd[1]), .busy(busy[1]), .done(done[1]),
    .underrun(underrun[1]), .col_seen(col_seen[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- wire monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] cap0[$];
  logic [3:0] cap1[$];
  int run_len[2], last_run[2], low_len[2], last_gap[2], rise_cyc[2];
  int done_cnt[2], und_cnt[2];
  int ifg_rdy_bad = 0;
  int idle_dat_bad = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0; last_run[i] = 0; low_len[i] = 0; last_gap[i] = 0;
      rise_cyc[i] = 0; done_cnt[i] = 0; und_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_en[i] === 1'b1) begin
        if (run_len[i] == 0) begin
          rise_cyc[i] = cyc;
          last_gap[i] = low_len[i];
        end
        run_len[i]++;
        low_len[i] = 0;
      end else if (tx_en[i] === 1'b0) begin
        if (run_len[i] != 0) last_run[i] = run_len[i];
        run_len[i] = 0;
        low_len[i]++;
        if (txd[i] !== 4'h0) idle_dat_bad++;
        if (busy[i] === 1'b1 && s_ready[i] === 1'b1) ifg_rdy_bad++;
      end
      if (done[i] === 1'b1) done_cnt[i]++;
      if (underrun[i] === 1'b1) und_cnt[i]++;
    end
    if (tx_en[0] === 1'b1) cap0.push_back(txd[0]);
    if (tx_en[1] === 1'b1) cap1.push_back(txd[1]);
  end

  // ---------------- reference model ----------------
  logic [7:0] pay[$];
  logic [3:0] exp_q[$];

  function automatic logic [31:0] crc_run(input logic [7:0] bq[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bq[k]) begin
      c = c ^ {24'h0, bq[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Appends the expected wire nibbles for a frame carrying the first
  // 'sent' payload bytes; incomplete frames have neither pad nor FCS.
  task automatic model_frame(input int minb, input int sent, input bit complete);
    logic [7:0]  fb[$];
    logic [31:0] fcs;
    for (int k = 0; k < 15; k++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    for (int k = 0; k < sent; k++) fb.push_back(pay[k]);
    if (complete) while (fb.size() < minb) fb.push_back(8'h00);
    foreach (fb[k]) begin
      exp_q.push_back(fb[k][3:0]);
      exp_q.push_back(fb[k][7:4]);
    end
    if (complete) begin
      fcs = ~crc_run(fb);
      for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
    end
  endtask

  task automatic cmp_stream(input string tag, input int w);
    int n, nd;
    logic [3:0] got;
    n  = (w == 1) ? cap1.size() : cap0.size();
    nd = 0;
    chk({tag, "_len"}, 64'(n), 64'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      got = (w == 1) ? cap1[k] : cap0[k];
      if (got !== exp_q[k]) nd++;
    end
    chk({tag, "_nibble_diffs"}, 64'(nd), 64'd0);
  endtask

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_frame(input int w, input int nbytes, input int stall_word,
                            output int acc_cyc);
    int nw, guard, idx;
    nw = (nbytes + 7) / 8;
    acc_cyc = -1;
    for (int k = 0; k < nw; k++) begin
      guard = 0;
      if (k == stall_word) begin
        s_valid[w] = 1'b0;
        while (s_ready[w] !== 1'b1 && guard < LIMIT) begin @(negedge clk); guard++; end
        chk("underrun_pulse", 64'(underrun[w]), 64'd1);
        @(negedge clk);
        return;
      end
      for (int b = 0; b < 8; b++) begin
        idx = 8 * k + b;
        s_data[w][8*b +: 8] = (idx < nbytes) ? pay[idx] : 8'($urandom);
      end
      s_valid[w] = 1'b1;
      s_last[w]  = (k == nw - 1);
      s_bytes[w] = (k == nw - 1) ? 4'(nbytes - 8 * k) : 4'd8;
      while (s_ready[w] !== 1'b1 && guard < LIMIT) begin @(negedge clk); guard++; end
      if (guard >= LIMIT) chk("handshake_timeout", 64'(guard), 64'd0);
      if (k == 0) acc_cyc = cyc;
      @(negedge clk);
    end
    s_valid[w] = 1'b0;
    s_last[w]  = 1'b0;
  endtask

  task automatic wait_idle(input int w);
    int guard;
    guard = 0;
    while (busy[w] !== 1'b0 && guard < LIMIT) begin @(negedge clk); guard++; end
    if (guard >= LIMIT) chk("idle_timeout", 64'(guard), 64'd0);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, u0, n, minb, cnt, w, hi;
    int lens[6];
    logic [31:0] fw;
    logic [7:0]  rb[$];

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_bytes[i] = '0; col[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tx_en",    64'(tx_en[0]),    64'd0);
    chk("rst_txd",      64'(txd[0]),      64'd0);
    chk("rst_s_ready",  64'(s_ready[0]),  64'd0);
    chk("rst_busy",     64'(busy[0]),     64'd0);
    chk("rst_done",     64'(done[0]),     64'd0);
    chk("rst_underrun", 64'(underrun[0]), 64'd0);
    chk("rst_col_seen", 64'(col_seen[0]), 64'd0);
    chk("rst_tx_en_b",  64'(tx_en[1]),    64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(s_ready[0]), 64'd1);
    @(negedge clk);

    // unpadded reference frame "123456789"
    pay.delete();
    for (int k = 0; k < 9; k++) pay.push_back(8'(8'h31 + k));
    cap1.delete(); exp_q.delete();
    d0 = done_cnt[1];
    send_frame(1, 9, -1, acc);
    wait_idle(1);
    model_frame(0, 9, 1);
    cmp_stream("nopad_123456789", 1);
    chk("nopad_latency", 64'(rise_cyc[1] - acc), 64'd1);
    chk("nopad_tx_en_len", 64'(last_run[1]), 64'd42);
    fw = '0;
    if (cap1.size() == 42) for (int k = 0; k < 8; k++) fw[4*k +: 4] = cap1[34 + k];
    chk("nopad_fcs", 64'(fw), 64'hCBF43926);
    chk("nopad_done_once", 64'(done_cnt[1] - d0), 64'd1);

    // padded reference frame
    cap0.delete(); exp_q.delete();
    send_frame(0, 9, -1, acc);
    wait_idle(0);
    model_frame(60, 9, 1);
    cmp_stream("pad_123456789", 0);
    chk("pad_latency", 64'(rise_cyc[0] - acc), 64'd1);
    chk("pad_tx_en_len", 64'(last_run[0]), 64'd144);
    rb.delete();
    for (int k = 16; k + 1 < cap0.size(); k += 2) rb.push_back({cap0[k + 1], cap0[k]});
    chk("pad_rx_residue", 64'(crc_run(rb)), 64'hDEBB20E3);

    // random payloads including pad-boundary lengths
    lens = '{8, 59, 60, 61, 1, 0};
    for (int r = 0; r < 10; r++) begin
      w    = r % 2;
      n    = (r < 6 && lens[r] != 0) ? lens[r] : int'($urandom_range(1, 90));
      minb = (w == 0) ? 60 : 0;
      rand_pay(n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (w == 0) cap0.delete(); else cap1.delete();
      exp_q.delete();
      send_frame(w, n, -1, acc);
      wait_idle(w);
      model_frame(minb, n, 1);
      cmp_stream($sformatf("rand%0d_n%0d", r, n), w);
      chk($sformatf("rand%0d_tx_en_len", r), 64'(last_run[w]),
          64'(16 + 2 * max_i(n, minb) + 8));
    end

    // underrun: 3-word frame, second word missing
    rand_pay(24);
    cap0.delete(); exp_q.delete();
    d0 = done_cnt[0]; u0 = und_cnt[0];
    send_frame(0, 24, 1, acc);
    chk("underrun_tx_en_drop", 64'(tx_en[0]), 64'd0);
    cnt = 1;
    while (s_ready[0] !== 1'b1 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    chk("underrun_ready_return", 64'(cnt), 64'd24);
    model_frame(60, 8, 0);
    cmp_stream("underrun_stream", 0);
    chk("underrun_count", 64'(und_cnt[0] - u0), 64'd1);
    chk("underrun_no_done", 64'(done_cnt[0] - d0), 64'd0);
    @(negedge clk);

    // back-to-back 64-byte frames
    cap0.delete(); exp_q.delete();
    rand_pay(64);
    model_frame(60, 64, 1);
    send_frame(0, 64, -1, acc);
    rand_pay(64);
    model_frame(60, 64, 1);
    send_frame(0, 64, -1, acc);
    wait_idle(0);
    cmp_stream("b2b_stream", 0);
    chk("b2b_gap", 64'(last_gap[0]), 64'd24);
    chk("b2b_tx_en_len", 64'(last_run[0]), 64'd152);

    // reset in the middle of payload
    rand_pay(40);
    u0 = und_cnt[0];
    for (int b = 0; b < 8; b++) s_data[0][8*b +: 8] = pay[b];
    s_valid[0] = 1'b1; s_last[0] = 1'b0; s_bytes[0] = 4'd8;
    cnt = 0;
    while (s_ready[0] !== 1'b1 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    @(negedge clk);
    s_valid[0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("midrst_running", 64'(tx_en[0]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx_en",    64'(tx_en[0]),    64'd0);
    chk("midrst_txd",      64'(txd[0]),      64'd0);
    chk("midrst_busy",     64'(busy[0]),     64'd0);
    chk("midrst_s_ready",  64'(s_ready[0]),  64'd0);
    chk("midrst_done",     64'(done[0]),     64'd0);
    chk("midrst_underrun", 64'(underrun[0]), 64'd0);
    chk("midrst_col_seen", 64'(col_seen[0]), 64'd0);
    rst_n = 1'b1;
    hi = 0;
    repeat (40) begin @(negedge clk); if (tx_en[0] === 1'b1) hi++; end
    chk("midrst_no_resume", 64'(hi), 64'd0);
    chk("midrst_no_underrun", 64'(und_cnt[0] - u0), 64'd0);

    // collision during preamble
    rand_pay(20);
    cap0.delete(); exp_q.delete();
    fork
      send_frame(0, 20, -1, acc);
      begin
        repeat (4) @(negedge clk);
        col[0] = 1'b1;
        @(negedge clk);
        col[0] = 1'b0;
      end
    join
    wait_idle(0);
    model_frame(60, 20, 1);
    cmp_stream("col_stream", 0);
    chk("col_seen_set", 64'(col_seen[0]), 64'd1);
    repeat (5) @(negedge clk);
    chk("col_seen_sticky", 64'(col_seen[0]), 64'd1);
    rand_pay(12);
    cap0.delete(); exp_q.delete();
    send_frame(0, 12, -1, acc);
    chk("col_seen_cleared", 64'(col_seen[0]), 64'd0);
    wait_idle(0);
    model_frame(60, 12, 1);
    cmp_stream("after_col_stream", 0);

    chk("idle_data_zero", 64'(idle_dat_bad), 64'd0);
    chk("no_ready_in_ifg", 64'(ifg_rdy_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
